// File: rtl/aes_encrypt_iter.sv
// Iterative AES-128 encryptor: one round per clock, round keys expanded on the fly.
// Define AES_ENC_DBG_EN to expose dbg_round / dbg_rk observation ports.
module aes_encrypt_iter #(
  parameter int unsigned NR    = 10,
  parameter int unsigned KEY_W = 128
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     plain_text,
  input  logic [KEY_W-1:0] key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     cipher_text,
  output logic             busy
`ifdef AES_ENC_DBG_EN
  ,
  output logic [3:0]       dbg_round,
  output logic [127:0]     dbg_rk
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // SubBytes and ShiftRows fused: row r of column c comes from column (c+r)%4.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = SBOX[s[127-8*(r+4*((c+r)%4)) -: 8]];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
    end
    return o;
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {SBOX[k[23:16]], SBOX[k[15:8]], SBOX[k[7:0]], SBOX[k[31:24]]} ^ {rc, 24'h0};
    w0 = k[127:96] ^ t;
    w1 = k[95:64]  ^ w0;
    w2 = k[63:32]  ^ w1;
    w3 = k[31:0]   ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  state_e       state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] st_q, st_d;
  logic [127:0] rk_q, rk_d;
  logic [127:0] ct_q, ct_d;

  logic [127:0] rk_next, sr, st_round, ct_final;

  assign rk_next  = key_expand(rk_q, rcon(round_q));
  assign sr       = sub_shift(st_q);
  assign st_round = mix_columns(sr) ^ rk_next;
  assign ct_final = sr ^ rk_next;

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    st_d    = st_q;
    rk_d    = rk_q;
    ct_d    = ct_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          st_d    = plain_text ^ key;
          rk_d    = key;
          round_d = 4'd1;
          state_d = ROUND;
        end
      end
      ROUND: begin
        rk_d = rk_next;
        if (round_q >= 4'(NR)) begin
          ct_d    = ct_final;
          round_d = '0;
          state_d = DONE;
        end else begin
          st_d    = st_round;
          round_d = round_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        round_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      round_q <= '0;
      st_q    <= '0;
      rk_q    <= '0;
      ct_q    <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      st_q    <= st_d;
      rk_q    <= rk_d;
      ct_q    <= ct_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q == ROUND);
  assign cipher_text = ct_q;

`ifdef AES_ENC_DBG_EN
  assign dbg_round = round_q;
  assign dbg_rk    = rk_q;
`endif

endmodule
